// File: rtl/demux16x32_seq_if.sv
// Bus bundle for demux16x32_seq.
//   D         write data word
//   S         explicit channel select (used when auto_inc=0)
//   wr_en     write strobe, one word per cycle
//   auto_inc  1: channel from internal pointer, 0: channel from S
//   clr       per-channel clear of valid/ovr
//   Q         registered per-channel data, Q[k] is channel k
//   valid     sticky "holds unread data" per channel
//   ovr       sticky overrun per channel
//   ptr       internal channel pointer
//   wrap      one-cycle pulse on auto pointer wrap 15->0
//   all_valid AND of all valid bits
interface demux16x32_seq_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0]             D;
    logic [3:0]                   S;
    logic                         wr_en;
    logic                         auto_inc;
    logic [15:0]                  clr;
    logic [15:0][WIDTH-1:0]       Q;
    logic [15:0]                  valid;
    logic [15:0]                  ovr;
    logic [3:0]                   ptr;
    logic                         wrap;
    logic                         all_valid;

    modport master (
        output D, S, wr_en, auto_inc, clr,
        input  Q, valid, ovr, ptr, wrap, all_valid
    );

    modport slave (
        input  D, S, wr_en, auto_inc, clr,
        output Q, valid, ovr, ptr, wrap, all_valid
    );
endinterface

// File: rtl/demux16x32_seq.sv
// 16-channel registered write demultiplexer with sticky valid/overrun flags
// and an auto-incrementing channel pointer.
//   clk  single clock, rising edge
//   rst  synchronous active-high reset, overrides every other input
//   bus  demux16x32_seq_if slave: write side (D, S, wr_en, auto_inc, clr)
//        in, per-channel state (Q, valid, ovr, ptr, wrap, all_valid) out
module demux16x32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    demux16x32_seq_if.slave  bus
);

    logic [15:0][WIDTH-1:0] q_r;
    logic [15:0]            valid_r;
    logic [15:0]            ovr_r;
    logic [3:0]             ptr_r;
    logic                   wrap_r;
    logic [3:0]             ch;
    logic [15:0]            hit;

    // Channel select follows the auto_inc value of the current cycle.
    always_comb begin
        ch  = bus.auto_inc ? ptr_r : bus.S;
        hit = '0;
        if (bus.wr_en) hit[ch] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= '0;
            valid_r <= '0;
            ovr_r   <= '0;
            ptr_r   <= '0;
            wrap_r  <= 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (hit[k]) begin
                    // Write wins over clr for data/valid; a simultaneous clr
                    // still wipes ovr instead of letting it set.
                    q_r[k]     <= bus.D;
                    valid_r[k] <= 1'b1;
                    ovr_r[k]   <= bus.clr[k] ? 1'b0 : (ovr_r[k] | valid_r[k]);
                end else if (bus.clr[k]) begin
                    valid_r[k] <= 1'b0;
                    ovr_r[k]   <= 1'b0;
                end
            end

            // Manual mode tracks S every cycle so switching to auto mode
            // resumes from the last channel addressed explicitly.
            if (bus.auto_inc) begin
                if (bus.wr_en) ptr_r <= ptr_r + 4'd1;
            end else begin
                ptr_r <= bus.S;
            end

            wrap_r <= bus.auto_inc && bus.wr_en && (ptr_r == 4'hF);
        end
    end

    assign bus.Q         = q_r;
    assign bus.valid     = valid_r;
    assign bus.ovr       = ovr_r;
    assign bus.ptr       = ptr_r;
    assign bus.wrap      = wrap_r;
    assign bus.all_valid = &valid_r;

endmodule

// File: tb/tb_demux16x32_seq.sv
module tb_demux16x32_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demux16x32_seq_if #(.WIDTH(32)) bus();

    demux16x32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.D = '0; bus.S = '0; bus.wr_en = 1'b0; bus.auto_inc = 1'b0; bus.clr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit qz;
        idle_inputs();
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.D = 32'h55; bus.S = 4'd2; bus.clr = 16'h0;
        step();
        step();
        qz = 1'b1;
        for (int k = 0; k < 16; k++) if (bus.Q[k] !== 32'h0) qz = 1'b0;
        checks++; if (qz !== 1'b1) begin errors++; $display("FAIL reset_q: some Q nonzero, required all 0"); end
        checks++; if (bus.valid !== 16'h0) begin errors++; $display("FAIL reset_valid: got %h required 0000", bus.valid); end
        checks++; if (bus.ovr !== 16'h0) begin errors++; $display("FAIL reset_ovr: got %h required 0000", bus.ovr); end
        checks++; if (bus.ptr !== 4'h0) begin errors++; $display("FAIL reset_ptr: got %0d required 0", bus.ptr); end
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b required 0", bus.wrap); end
        checks++; if (bus.all_valid !== 1'b0) begin errors++; $display("FAIL reset_all_valid: got %b required 0", bus.all_valid); end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_manual_write();
        bit others;
        do_reset();
        bus.S = 4'd5; bus.D = 32'hDEADBEEF; bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.D = 32'h12345678;
        checks++; if (bus.Q[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL manual_q5: got %h required deadbeef", bus.Q[5]); end
        checks++; if (bus.valid !== 16'h0020) begin errors++; $display("FAIL manual_valid: got %h required 0020", bus.valid); end
        checks++; if (bus.ovr !== 16'h0) begin errors++; $display("FAIL manual_ovr: got %h required 0000", bus.ovr); end
        others = 1'b1;
        for (int k = 0; k < 16; k++) if (k != 5 && bus.Q[k] !== 32'h0) others = 1'b0;
        checks++; if (others !== 1'b1) begin errors++; $display("FAIL manual_others: another Q changed, required 0"); end
        step();
        checks++; if (bus.Q[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL manual_hold: got %h required deadbeef", bus.Q[5]); end
        checks++; if (bus.ptr !== 4'd5) begin errors++; $display("FAIL manual_ptr_load: got %0d required 5", bus.ptr); end
    endtask

    task automatic test_auto_scan();
        bit qok;
        do_reset();
        bus.auto_inc = 1'b1; bus.wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.D = i;
            step();
            checks++; if (bus.ptr !== 4'((i + 1) % 16)) begin errors++; $display("FAIL scan_ptr[%0d]: got %0d required %0d", i, bus.ptr, (i + 1) % 16); end
            checks++; if (bus.wrap !== (i == 15)) begin errors++; $display("FAIL scan_wrap[%0d]: got %b required %b", i, bus.wrap, i == 15); end
        end
        bus.wr_en = 1'b0;
        step();
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL scan_wrap_end: got %b required 0", bus.wrap); end
        checks++; if (bus.ptr !== 4'd0) begin errors++; $display("FAIL scan_ptr_hold: got %0d required 0", bus.ptr); end
        qok = 1'b1;
        for (int k = 0; k < 16; k++) if (bus.Q[k] !== 32'(k)) qok = 1'b0;
        checks++; if (qok !== 1'b1) begin errors++; $display("FAIL scan_q: some Qk differs from required k"); end
        checks++; if (bus.valid !== 16'hFFFF) begin errors++; $display("FAIL scan_valid: got %h required ffff", bus.valid); end
        checks++; if (bus.all_valid !== 1'b1) begin errors++; $display("FAIL scan_all_valid: got %b required 1", bus.all_valid); end
        checks++; if (bus.ovr !== 16'h0) begin errors++; $display("FAIL scan_ovr: got %h required 0000", bus.ovr); end
    endtask

    task automatic test_overrun();
        do_reset();
        bus.S = 4'd3; bus.wr_en = 1'b1; bus.D = 32'h1;
        step();
        bus.D = 32'h2;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.Q[3] !== 32'h2) begin errors++; $display("FAIL ovr_q3: got %h required 2", bus.Q[3]); end
        checks++; if (bus.ovr !== 16'h0008) begin errors++; $display("FAIL ovr_set: got %h required 0008", bus.ovr); end
        bus.clr = 16'h0008;
        step();
        bus.clr = '0;
        checks++; if (bus.valid !== 16'h0) begin errors++; $display("FAIL ovr_clr_valid: got %h required 0000", bus.valid); end
        checks++; if (bus.ovr !== 16'h0) begin errors++; $display("FAIL ovr_clr_ovr: got %h required 0000", bus.ovr); end
        checks++; if (bus.Q[3] !== 32'h2) begin errors++; $display("FAIL ovr_clr_q3: got %h required 2", bus.Q[3]); end
    endtask

    task automatic test_collision();
        do_reset();
        bus.wr_en = 1'b1;
        bus.S = 4'd7; bus.D = 32'h1; step();
        bus.S = 4'd7; bus.D = 32'h2; step();
        bus.S = 4'd3; bus.D = 32'h3; step();
        checks++; if (bus.valid !== 16'h0088 || bus.ovr !== 16'h0080) begin errors++; $display("FAIL coll_setup: valid %h ovr %h required 0088 0080", bus.valid, bus.ovr); end
        bus.S = 4'd7; bus.D = 32'hAA; bus.clr = 16'h0088;
        step();
        bus.wr_en = 1'b0; bus.clr = '0;
        checks++; if (bus.Q[7] !== 32'hAA) begin errors++; $display("FAIL coll_q7: got %h required aa", bus.Q[7]); end
        checks++; if (bus.valid !== 16'h0080) begin errors++; $display("FAIL coll_valid: got %h required 0080", bus.valid); end
        checks++; if (bus.ovr !== 16'h0) begin errors++; $display("FAIL coll_ovr: got %h required 0000", bus.ovr); end
    endtask

    task automatic test_reset_mid_scan();
        bit qz;
        do_reset();
        bus.auto_inc = 1'b1; bus.wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.D = 32'h10 + i;
            step();
        end
        checks++; if (bus.ptr !== 4'd9) begin errors++; $display("FAIL rmid_ptr9: got %0d required 9", bus.ptr); end
        rst = 1'b1; bus.D = 32'h55;
        step();
        rst = 1'b0; bus.wr_en = 1'b0;
        qz = 1'b1;
        for (int k = 0; k < 16; k++) if (bus.Q[k] !== 32'h0) qz = 1'b0;
        checks++; if (qz !== 1'b1) begin errors++; $display("FAIL rmid_q: some Q nonzero, required all 0"); end
        checks++; if (bus.valid !== 16'h0 || bus.ptr !== 4'd0) begin errors++; $display("FAIL rmid_state: valid %h ptr %0d required 0000 0", bus.valid, bus.ptr); end
        bus.wr_en = 1'b1; bus.D = 32'h77;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.Q[0] !== 32'h77) begin errors++; $display("FAIL rmid_q0: got %h required 77", bus.Q[0]); end
        checks++; if (bus.ptr !== 4'd1 || bus.valid !== 16'h0001) begin errors++; $display("FAIL rmid_after: ptr %0d valid %h required 1 0001", bus.ptr, bus.valid); end
    endtask

    task automatic test_mode_switch();
        int wraps;
        do_reset();
        // Manual loads through 15 and back to 0 never pulse wrap.
        bus.S = 4'd15; step();
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL man_wrap15: got %b required 0", bus.wrap); end
        bus.S = 4'd0; step();
        checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL man_wrap0: got %b required 0", bus.wrap); end
        bus.S = 4'd14; step();
        checks++; if (bus.ptr !== 4'd14) begin errors++; $display("FAIL sw_ptr14: got %0d required 14", bus.ptr); end
        wraps = 0;
        bus.auto_inc = 1'b1; bus.wr_en = 1'b1; bus.S = 4'd2;
        bus.D = 32'hA; step(); if (bus.wrap === 1'b1) wraps++;
        bus.D = 32'hB; step(); if (bus.wrap === 1'b1) wraps++;
        bus.D = 32'hC; step(); if (bus.wrap === 1'b1) wraps++;
        bus.wr_en = 1'b0;
        step(); if (bus.wrap === 1'b1) wraps++;
        checks++; if (bus.Q[14] !== 32'hA || bus.Q[15] !== 32'hB || bus.Q[0] !== 32'hC) begin errors++; $display("FAIL sw_q: Q14 %h Q15 %h Q0 %h required a b c", bus.Q[14], bus.Q[15], bus.Q[0]); end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL sw_wraps: got %0d required 1", wraps); end
        checks++; if (bus.ptr !== 4'd1) begin errors++; $display("FAIL sw_ptr: got %0d required 1", bus.ptr); end
        // Dropping auto_inc in the write cycle selects S, not ptr.
        bus.auto_inc = 1'b0; bus.S = 4'd9; bus.D = 32'h99; bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.Q[9] !== 32'h99 || bus.Q[1] !== 32'h0) begin errors++; $display("FAIL sw_back_manual: Q9 %h Q1 %h required 99 0", bus.Q[9], bus.Q[1]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_manual_write();
        test_auto_scan();
        test_overrun();
        test_collision();
        test_reset_mid_scan();
        test_mode_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux16x32_seq.md
DEMUX16X32_SEQ -- requirements
Module: demux16x32_seq

Interface
REQ-001 Parameter WIDTH, default 32: data word width; all data ports and output registers SHALL be WIDTH bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 D  input  WIDTH  write data word.
REQ-005 S  input  4  explicit channel select, used when auto_inc=0.
REQ-006 wr_en  input  1  write strobe; one word accepted per cycle it is high.
REQ-007 auto_inc  input  1  1 = channel taken from internal pointer; 0 = channel taken from S.
REQ-008 clr  input  16  per-channel clear of valid and ovr flags.
REQ-009 Q0..Q15  output  WIDTH each  registered per-channel data.
REQ-010 valid  output  16  per-channel sticky "holds unread data" flag.
REQ-011 ovr  output  16  per-channel sticky overrun flag.
REQ-012 ptr  output  4  current internal channel pointer.
REQ-013 wrap  output  1  one-cycle pulse on pointer wrap 15->0.
REQ-014 all_valid  output  1  high when all 16 valid bits are 1.

Function
REQ-015 Target channel ch SHALL be S when auto_inc=0, ptr when auto_inc=1, sampled in the cycle wr_en is high.
REQ-016 Write accepted in cycle n SHALL make Q[ch] equal D at cycle n+1 (one-cycle latency); all other Q SHALL hold.
REQ-017 With wr_en=0, all Q SHALL hold; Q SHALL change only through writes or rst.
REQ-018 An accepted write SHALL set valid[ch] at the same edge Q[ch] is updated.
REQ-019 If valid[ch]=1 before the edge and a write to ch occurs without clr[ch], ovr[ch] SHALL be set; data SHALL still be overwritten.
REQ-020 clr[k]=1 without a write to k SHALL clear valid[k] and ovr[k] at the next edge.
REQ-021 Write and clr[k] on the same channel in the same cycle: write wins for data and valid (Q[k]=D, valid[k]=1), and ovr[k] SHALL be cleared, not set.
REQ-022 clr bits for non-targeted channels SHALL act independently in the same cycle as a write.
REQ-023 auto_inc=1 with wr_en=1: ptr SHALL increment by 1 modulo 16 at the edge; auto_inc=1 with wr_en=0: ptr SHALL hold.
REQ-024 auto_inc=0: ptr SHALL load S every cycle, so a switch to auto_inc=1 begins at the last S presented.
REQ-025 wrap SHALL be 1 for exactly the cycle after an auto-mode write that takes ptr from 15 to 0, else 0; manual-mode ptr loads SHALL never raise wrap.
REQ-026 all_valid SHALL be the AND of the registered valid bits (no extra latency beyond valid).
REQ-027 auto_inc changing in the same cycle as wr_en SHALL use the new auto_inc value for channel selection in that cycle.

Reset
REQ-028 rst=1 at an edge SHALL force Q0..Q15=0, valid=0, ovr=0, ptr=0, wrap=0; all_valid SHALL then be 0.
REQ-029 rst SHALL take precedence over wr_en, clr and auto_inc in the same cycle; a write presented with rst SHALL be discarded.
REQ-030 rst asserted mid auto-scan SHALL restart scanning at channel 0 once rst is released with auto_inc=1.

Verification
REQ-031 Manual write: rst, then S=5, D=0xDEADBEEF, wr_en=1 for one cycle -> next cycle Q5=0xDEADBEEF, valid=0x0020, all other Q=0, ovr=0.
REQ-032 Auto scan: rst, auto_inc=1, 16 back-to-back writes D=0..15 -> Qk=k, valid=0xFFFF, all_valid=1, ptr=0, wrap=1 for exactly one cycle after the 16th write.
REQ-033 Overrun: write 0x1 to ch3, then write 0x2 to ch3 -> Q3=0x2, ovr=0x0008; then clr=0x0008 -> valid[3]=0, ovr[3]=0.
REQ-034 Collision: valid[7]=1, ovr[7]=1; write 0xAA to ch7 with clr=0x0088 same cycle -> Q7=0xAA, valid[7]=1, ovr[7]=0, valid[3]=0.
REQ-035 Reset mid-operation: auto_inc=1, 9 writes (ptr=9), then rst with wr_en=1, D=0x55 -> all Q=0, valid=0, ptr=0, no write of 0x55; next auto write lands in Q0.
REQ-036 Mode switch: auto_inc=0, S=14 held, then auto_inc=1 with 3 writes D=0xA,0xB,0xC -> Q14=0xA, Q15=0xB, Q0=0xC, wrap pulsed once, ptr=1.
